// File: rtl/dii_pkg.sv
// Shared DII (debug interconnect) types used by the ring-side arbiters.
package dii_pkg;

  localparam int DII_FLIT_WIDTH = 16;

  typedef struct packed {
    logic                      last;
    logic [DII_FLIT_WIDTH-1:0] data;
  } dii_flit_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dii_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Shared by the ring-side arbiters.
module dii_rr_select #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  sel_onehot,
  output logic [IW-1:0] sel_idx,
  output logic          found
);

  // Scan N positions starting at ptr and keep the first requester found.
  always_comb begin
    int idx;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel_idx    = '0;
    found      = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[IW'(idx)]) begin
        found   = 1'b1;
        sel_idx = IW'(idx);
      end
    end
    if (found) sel_onehot = N'(1) << sel_idx;
  end

endmodule

// File: rtl/dii_ring_arbiter.sv
// Packet-atomic round-robin merge of N DII channels onto one registered
// DII channel toward a debug-ring injection port.
module dii_ring_arbiter
  import dii_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*DII_FLIT_WIDTH-1:0] in_data,
  input  logic [N-1:0]                in_last,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  output logic [DII_FLIT_WIDTH-1:0]   out_data,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                grant,
  output logic                        busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          pick_found;
  logic [IW-1:0] sel;
  logic [IW-1:0] sel_next;
  logic [N-1:0]  owner_onehot;
  logic          stage_free;
  logic          xfer;
  dii_flit_t     sel_flit;
  dii_flit_t     out_flit;

  dii_rr_select #(.N(N)) u_pick (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .sel_onehot (pick_onehot),
    .sel_idx    (pick_idx),
    .found      (pick_found)
  );

  assign busy         = (state == ARB_LOCKED);
  assign owner_onehot = N'(1) << owner;
  assign grant        = busy ? owner_onehot : '0;
  assign stage_free   = !out_valid || out_ready;

  // Source selection, handshake and next round-robin position.
  always_comb begin
    sel               = busy ? owner : pick_idx;
    sel_flit.data     = in_data[int'(sel)*DII_FLIT_WIDTH +: DII_FLIT_WIDTH];
    sel_flit.last     = in_last[sel];
    sel_next          = (sel == IW'(N-1)) ? '0 : sel + 1'b1;
    if (busy) begin
      xfer     = stage_free && in_valid[owner];
      in_ready = (stage_free && !rst) ? owner_onehot : '0;
    end else begin
      xfer     = stage_free && pick_found;
      in_ready = (stage_free && !rst) ? pick_onehot : '0;
    end
  end

  // Packet ownership and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (sel_flit.last) begin
        state  <= ARB_IDLE;
        rr_ptr <= sel_next;
      end else if (!busy) begin
        state <= ARB_LOCKED;
        owner <= sel;
      end
    end
  end

  // Registered output stage; holds the flit while the ring stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the flit payload is reset too, so out_data/out_last read 0 after reset.
      out_flit  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_flit  <= sel_flit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = out_flit.data;
  assign out_last = out_flit.last;

endmodule

// File: tb/tb_dii_ring_arbiter.sv
// Self-checking bench for dii_ring_arbiter (N=3) with an output scoreboard.
module tb_dii_ring_arbiter;
  import dii_pkg::*;

  localparam int N = 3;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [N*DII_FLIT_WIDTH-1:0] in_data = '0;
  logic [N-1:0]                in_last = '0;
  logic [N-1:0]                in_valid = '0;
  logic [N-1:0]                in_ready;
  logic [DII_FLIT_WIDTH-1:0]   out_data;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [N-1:0]                grant;
  logic                        busy;

  dii_ring_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int        n_compared = 0;
  int        n_mismatched = 0;
  int        cyc = 0;
  dii_flit_t src_q [N][$];
  dii_flit_t exp_q [$];
  int        out_cycles [$];
  logic [N-1:0] pause = '0;
  logic      ordy = 1'b1;
  logic      chk_stall = 1'b0;
  logic      chk_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_pkt(input int r, input int p, input int len);
    dii_flit_t fl;
    for (int f = 0; f < len; f++) begin
      fl.data = {r[3:0], p[3:0], f[7:0]};
      fl.last = (f == len - 1);
      src_q[r].push_back(fl);
      exp_q.push_back(fl);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, retire handshakes after posedge.
  task automatic step();
    logic [N-1:0] hs;
    dii_flit_t    e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !pause[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*DII_FLIT_WIDTH +: DII_FLIT_WIDTH] = src_q[i][0].data;
        in_last[i] = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DII_FLIT_WIDTH +: DII_FLIT_WIDTH] = '0;
        in_last[i] = 1'b0;
      end
    end
    out_ready = ordy;
    #1;
    hs = in_valid & in_ready;
    check("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
    if (busy) check("grant_onehot", 32'($countones(grant)), 32'd1);
    else      check("grant_idle", 32'(grant), 32'd0);
    if (chk_stall) begin
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() > 0) check("stall_hold", {15'd0, out_last, out_data}, {15'd0, exp_q[0].last, exp_q[0].data});
    end
    if (chk_hold) begin
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_ready1", 32'(in_ready[1]), 32'd0);
      check("hold_grant", 32'(grant), 32'b001);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_flit", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_flit", {15'd0, out_last, out_data}, {15'd0, e.last, e.data});
        out_cycles.push_back(cyc);
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    pause = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dii_flit_t fl;

    // Reset state and a single-flit packet from requester 1.
    apply_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    fl.data = 16'h1234;
    fl.last = 1'b1;
    src_q[1].push_back(fl);
    exp_q.push_back(fl);
    step();
    #1;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data", 32'(out_data), 32'h1234);
    check("t1_busy", 32'(busy), 32'd0);
    drain();
    check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd2);

    // Requesters 0 and 2 each send a 3-flit packet together.
    apply_reset();
    out_cycles.delete();
    load_pkt(0, 0, 3);
    load_pkt(2, 0, 3);
    drain();
    check("t2_count", 32'(out_cycles.size()), 32'd6);
    if (out_cycles.size() == 6) check("t2_span", 32'(out_cycles[5] - out_cycles[0]), 32'd5);

    // All three continuously valid with 2-flit packets: 0,1,2,0,1,2.
    out_cycles.delete();
    for (int p = 1; p <= 2; p++)
      for (int r = 0; r < N; r++) load_pkt(r, p, 2);
    drain();
    check("t3_count", 32'(out_cycles.size()), 32'd12);
    if (out_cycles.size() == 12) check("t3_span", 32'(out_cycles[11] - out_cycles[0]), 32'd11);

    // Downstream stall for 5 cycles mid-packet.
    load_pkt(0, 3, 4);
    load_pkt(1, 3, 2);
    step();
    step();
    ordy = 1'b0;
    chk_stall = 1'b1;
    repeat (5) step();
    chk_stall = 1'b0;
    ordy = 1'b1;
    drain();

    // Owner drops valid for 4 cycles while requester 1 waits.
    load_pkt(0, 4, 3);
    load_pkt(1, 4, 1);
    step();
    pause = 3'b001;
    chk_hold = 1'b1;
    repeat (4) step();
    chk_hold = 1'b0;
    pause = '0;
    drain();

    // Reset asserted during the second flit of a 4-flit packet.
    load_pkt(1, 5, 4);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    apply_reset();
    check("t6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    load_pkt(0, 6, 1);
    load_pkt(2, 6, 1);
    drain();
    step();
    check("end_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
